seq_shift_unit: RTL and testbench

//   Parametrised multi-cycle shifter for the datapath. Supports LSL, LSR, ASR and ROR

---
 rtl/seq_shift_unit_pkg.sv | 24 ++
 rtl/seq_shift_unit_step.sv | 63 ++++++
 rtl/seq_shift_unit.sv | 90 +++++++++
 tb/tb_seq_shift_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_shift_unit_pkg.sv
// Shared types and constants for the sequential shifter (package shift_pkg).
// Holds shift mode and FSM state encodings plus the multi-bit step size.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_LSL = 2'd0,
        MODE_LSR = 2'd1,
        MODE_ASR = 2'd2,
        MODE_ROR = 2'd3
    } mode_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

    localparam int unsigned MULTI_STEP = 4;

endpackage

// File: rtl/seq_shift_unit_step.sv
// shift_step: combinational single shift step of 1 or MULTI_STEP bits.
// c_next is the last bit shifted out (for ROR this is the new MSB).
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       mode,
    input  logic             multi,
    output logic [WIDTH-1:0] y_next,
    output logic             c_next
);

    always_comb begin
        y_next = y;
        c_next = 1'b0;
        case (mode_t'(mode))
            MODE_LSL: begin
                if (multi) begin
                    y_next = y << MULTI_STEP;
                    c_next = y[WIDTH-MULTI_STEP];
                end else begin
                    y_next = {y[WIDTH-2:0], 1'b0};
                    c_next = y[WIDTH-1];
                end
            end
            MODE_LSR: begin
                if (multi) begin
                    y_next = y >> MULTI_STEP;
                    c_next = y[MULTI_STEP-1];
                end else begin
                    y_next = {1'b0, y[WIDTH-1:1]};
                    c_next = y[0];
                end
            end
            MODE_ASR: begin
                if (multi) begin
                    y_next = $unsigned($signed(y) >>> MULTI_STEP);
                    c_next = y[MULTI_STEP-1];
                end else begin
                    y_next = {y[WIDTH-1], y[WIDTH-1:1]};
                    c_next = y[0];
                end
            end
            MODE_ROR: begin
                // Last bit rotated out lands in the MSB, so C mirrors the new MSB.
                if (multi) begin
                    y_next = (y >> MULTI_STEP) | (y << (WIDTH - MULTI_STEP));
                    c_next = y[MULTI_STEP-1];
                end else begin
                    y_next = {y[0], y[WIDTH-1:1]};
                    c_next = y[0];
                end
            end
            default: begin
                y_next = y;
                c_next = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle LSL/LSR/ASR/ROR shifter with Start/Ready handshake and Done pulse.
// Optional SEQ_SHIFT_MULTISTEP_EN: 4-bit steps while the remaining count is >= 4.
//
//   state | meaning
//   IDLE  | waiting for Start, Y/C hold last result
//   SHIFT | stepping Y once per cycle until cnt reaches zero
//   DONE  | Done pulse; a Start here loads the next op back-to-back
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Start,
    input  logic [1:0]       Mode,
    input  logic [AMT_W-1:0] Amount,
    input  logic [WIDTH-1:0] A,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] Y,
    output logic             C
);

    state_t           state;
    logic [AMT_W-1:0] cnt;
    logic [AMT_W-1:0] cnt_dec;
    logic [AMT_W-1:0] cnt_next;
    logic [1:0]       mode_q;
    logic             multi;
    logic [WIDTH-1:0] y_step;
    logic             c_step;

`ifdef SEQ_SHIFT_MULTISTEP_EN
    assign multi   = (32'(cnt) >= MULTI_STEP);
    assign cnt_dec = multi ? AMT_W'(MULTI_STEP) : AMT_W'(1);
`else
    assign multi   = 1'b0;
    assign cnt_dec = AMT_W'(1);
`endif

    assign cnt_next = cnt - cnt_dec;
    assign Ready    = (state == IDLE) || (state == DONE);
    assign Done     = (state == DONE);

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .y      (Y),
        .mode   (mode_q),
        .multi  (multi),
        .y_next (y_step),
        .c_next (c_step)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state  <= IDLE;
            Y      <= '0;
            C      <= 1'b0;
            cnt    <= '0;
            mode_q <= MODE_LSL;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        Y      <= A;
                        C      <= 1'b0;
                        cnt    <= Amount;
                        mode_q <= Mode;
                        state  <= (Amount == '0) ? DONE : SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    Y   <= y_step;
                    C   <= c_step;
                    cnt <= cnt_next;
                    if (cnt_next == '0) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: expected Y/C/latency queued at Start,
// popped and compared on each Done pulse.
module tb_seq_shift_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [3:0]  amount = 4'd0;
    logic [15:0] a = 16'h0000;
    logic        ready;
    logic        done;
    logic [15:0] y;
    logic        c;

    seq_shift_unit #(
        .WIDTH (16),
        .AMT_W (4)
    ) dut (
        .Clock  (clk),
        .nReset (rst_n),
        .Start  (start),
        .Mode   (mode),
        .Amount (amount),
        .A      (a),
        .Ready  (ready),
        .Done   (done),
        .Y      (y),
        .C      (c)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] y;
        logic        c;
        int          lat;
        int          t0;
        string       tag;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_miss = 0;
    logic [15:0] last_y = 16'h0000;
    logic        last_c = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input int amt);
`ifdef SEQ_SHIFT_MULTISTEP_EN
        return amt / 4 + amt % 4 + 1;
`else
        return amt + 1;
`endif
    endfunction

    function automatic void model(input logic [1:0] m, input int amt, input logic [15:0] a_in,
                                  output logic [15:0] yo, output logic co);
        yo = a_in;
        co = 1'b0;
        for (int i = 0; i < amt; i++) begin
            case (m)
                2'd0: begin co = yo[15]; yo = {yo[14:0], 1'b0}; end
                2'd1: begin co = yo[0];  yo = {1'b0, yo[15:1]}; end
                2'd2: begin co = yo[0];  yo = {yo[15], yo[15:1]}; end
                default: begin co = yo[0]; yo = {yo[0], yo[15:1]}; end
            endcase
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                check_val("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check_val({e.tag, "_y"}, 32'(y), 32'(e.y));
                check_val({e.tag, "_c"}, 32'(c), 32'(e.c));
                check_val({e.tag, "_lat"}, 32'(cyc - e.t0), 32'(e.lat));
                last_y = e.y;
                last_c = e.c;
            end
        end
    end

    task automatic push_exp(input string tag, input logic [15:0] ey, input logic ec, input int amt);
        exp_t e;
        e.y   = ey;
        e.c   = ec;
        e.lat = exp_lat(amt);
        e.t0  = cyc;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic issue(input string tag, input logic [1:0] m, input logic [3:0] amt,
                         input logic [15:0] av, input bit track,
                         input logic [15:0] ey, input logic ec);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check_val({tag, "_ready_timeout"}, 32'd0, 32'd1);
        mode   = m;
        amount = amt;
        a      = av;
        start  = 1'b1;
        if (track) push_exp(tag, ey, ec, int'(amt));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue_model(input string tag, input logic [1:0] m, input logic [3:0] amt,
                               input logic [15:0] av);
        logic [15:0] ey;
        logic        ec;
        model(m, int'(amt), av, ey, ec);
        issue(tag, m, amt, av, 1'b1, ey, ec);
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || !ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) check_val("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] ey;
        logic        ec;
        int          n;

        repeat (3) @(negedge clk);
        check_val("rst_ready", 32'(ready), 32'd1);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_y", 32'(y), 32'd0);
        check_val("rst_c", 32'(c), 32'd0);
        rst_n = 1'b1;

        issue("asr4", 2'd2, 4'd4, 16'h8010, 1'b1, 16'hF801, 1'b0);
        issue("ror1", 2'd3, 4'd1, 16'h0001, 1'b1, 16'h8000, 1'b1);
        issue("lsl1", 2'd0, 4'd1, 16'hC000, 1'b1, 16'h8000, 1'b1);
        issue("lsl0", 2'd0, 4'd0, 16'hC000, 1'b1, 16'hC000, 1'b0);
        issue("lsr15", 2'd1, 4'd15, 16'hFFFF, 1'b1, 16'h0001, 1'b1);
        drain();

        repeat (5) @(negedge clk);
        check_val("idle_y", 32'(y), 32'(last_y));
        check_val("idle_c", 32'(c), 32'(last_c));
        check_val("idle_ready", 32'(ready), 32'd1);

        // Start pulses with different operands while the first op is still shifting.
        issue_model("ignore", 2'd1, 4'd15, 16'hA5C3);
        mode   = 2'd0;
        amount = 4'd1;
        a      = 16'hFFFF;
        start  = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        drain();

        // Back-to-back: Start asserted during the Done cycle of the previous op.
        issue_model("b2b_1", 2'd0, 4'd3, 16'h1234);
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!done) check_val("b2b_done_timeout", 32'd0, 32'd1);
        model(2'd3, 5, 16'hBEEF, ey, ec);
        mode   = 2'd3;
        amount = 4'd5;
        a      = 16'hBEEF;
        start  = 1'b1;
        push_exp("b2b_2", ey, ec, 5);
        @(negedge clk);
        start = 1'b0;
        check_val("b2b_done_low", 32'(done), 32'd0);
        drain();

        for (int i = 0; i < 20; i++) begin
            issue_model($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)),
                        4'($urandom_range(0, 15)), 16'($urandom));
        end
        drain();

        // Asynchronous reset in the middle of a long shift.
        issue("rst_mid", 2'd1, 4'd15, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_y", 32'(y), 32'd0);
        check_val("midrst_c", 32'(c), 32'd0);
        check_val("midrst_done", 32'(done), 32'd0);
        check_val("midrst_ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_val("postrst_ready", 32'(ready), 32'd1);
        check_val("postrst_y", 32'(y), 32'd0);

        issue_model("post_rst_op", 2'd2, 4'd7, 16'h9ABC);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
